rf_row_mover: RTL and testbench
===============================

// Module: rf_row_mover
// PURPOSE
//   Command-driven row copy engine sitting directly upstream of the register-file RAM/MMIO decoder.
//   Each command copies LEN rows of RF_DATA_W bits from a source row address to a destination row address.
//   Each address advances by its own stride, so a stride of 0 streams rows into one MMIO port, e.g. STMM_0_X at 0x200.
//   It drives the register file's single-port BRAM-style port (addr/data/we/re, 1-cycle read latency on q).
// PARAMETERS
//   RF_DATA_W  1408  row width in bits
//   RF_ADDR_W  10    row address width; all address arithmetic is modulo 2**RF_ADDR_W
// PORTS
//   clk           in   1              single clock, all logic on posedge
//   rst           in   1              asynchronous, active-high reset
//   cmd_valid     in   1              command request
//   cmd_ready     out  1              high only in IDLE
//   cmd_src       in   RF_ADDR_W      first source row
//   cmd_dst       in   RF_ADDR_W      first destination row
//   cmd_src_step  in   RF_ADDR_W      source stride, unsigned, wraps
//   cmd_dst_step  in   RF_ADDR_W      destination stride, unsigned, wraps
//   cmd_len       in   RF_ADDR_W+1    rows to copy, 0..2**RF_ADDR_W
//   abort         in   1              stop current command early
//   busy          out  1              high in any state other than IDLE
//   done          out  1              1-cycle pulse at end of command
//   done_aborted  out  1              valid with done; 1 if the command ended by abort
//   rows_done     out  RF_ADDR_W+1    writes completed in current/last command
//   ram_addr      out  RF_ADDR_W      to register file addr
//   ram_data      out  RF_DATA_W      to register file data
//   ram_we        out  1              to register file we
//   ram_re        out  1              to register file re
//   ram_q         in   RF_DATA_W      register file q, valid one cycle after ram_re
// BEHAVIOUR
//   Reset values: IDLE state, cmd_ready=1, busy=0, done=0, done_aborted=0, rows_done=0.
//   Reset values (continued): ram_addr=0, ram_data=0, ram_we=0, ram_re=0, all internal counters and latches cleared.
//   Output timing: every output is registered or a pure decode of the registered state; there is no path from ram_q to ram_data.
//   Handshake: a command is accepted when cmd_valid && cmd_ready; fields are latched on that edge.
//   cmd_valid is ignored outside IDLE.
//   On acceptance, rows_done is cleared to 0.
//   States: IDLE -> RD -> LAT -> WR -> (RD | FIN) -> IDLE.
//   RD:  ram_re=1, ram_addr=src_ptr.
//   LAT: no access (re=we=0); data_r <= ram_q.
//   WR:  ram_we=1, ram_addr=dst_ptr, ram_data=data_r.
//   On leaving WR: rows_done++, src_ptr += src_step, dst_ptr += dst_step, both mod 2**RF_ADDR_W.
//   Leaving WR goes to FIN when rows_done+1 == len, else to RD.
//   FIN: done=1 for exactly one cycle, then IDLE.
//   ram_re and ram_we are never high in the same cycle; both are 0 in IDLE, LAT and FIN.
//   Latency: accept at edge 0, first RD in cycle 1, WR of row k in cycle 3k+3 (k from 0).
//   Latency (continued): done in cycle 3*len+1, cmd_ready again in cycle 3*len+2.
//   len=0: go straight from acceptance to FIN; done in cycle 1 with no RAM access and done_aborted=0.
//   len=2**RF_ADDR_W is legal; rows_done reaches 1024 at the default width.
//   abort, sampled in RD or LAT: go to FIN, issue no further access; the row in flight is not written.
//   abort, sampled in WR: the write completes and counts, then go to FIN.
//   abort, sampled in IDLE or FIN: ignored.
//   done_aborted=1 on the FIN pulse if abort caused it, even when it came on the last row's WR.
//   Overlap: src and dst ranges may overlap; copies proceed strictly in row order with no hazard protection.
//   Reset mid-operation: ram_we/ram_re drop immediately (asynchronously); no done pulse; return to IDLE.
// TESTING
//   Plain copy: src=0x010, dst=0x100, steps 1/1, len=4, RAM preloaded -> rows 0x100..0x103 match 0x010..0x013; done at cycle 13; rows_done=4.
//   Zero stride into MMIO: src=0x020, dst=0x200, steps 1/0, len=3 -> three writes to 0x200 with rows 0x020,0x021,0x022 in order.
//   Zero stride (check): no write to any other address during that command.
//   Address wrap: src=0x3FE, dst=0x0F0, len=4 -> reads 0x3FE,0x3FF,0x000,0x001; writes 0x0F0..0x0F3.
//   len=0 -> done (done_aborted=0) in cycle 1; ram_re/ram_we never asserted; cmd_ready back in cycle 2.
//   Abort: len=8, abort pulsed in cycle 8 (LAT of row 2) -> rows_done=2, row 2 not written, done_aborted=1.
//   Reset mid-operation: assert rst in a WR cycle -> ram_we low with no clock edge; no done pulse.
//   Reset (continued): after release cmd_ready=1, and a new len=1 command completes normally.

Source files
------------

// File: rtl/rf_row_mover.sv
// Row copy engine: streams LEN rows from a strided source to a strided
// destination through the register file's single-port RAM interface.
module rf_row_mover #(
  parameter int unsigned RF_DATA_W = 1408,
  parameter int unsigned RF_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [RF_ADDR_W-1:0] cmd_src,
  input  logic [RF_ADDR_W-1:0] cmd_dst,
  input  logic [RF_ADDR_W-1:0] cmd_src_step,
  input  logic [RF_ADDR_W-1:0] cmd_dst_step,
  input  logic [RF_ADDR_W:0]   cmd_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 done_aborted,
  output logic [RF_ADDR_W:0]   rows_done,
  output logic [RF_ADDR_W-1:0] ram_addr,
  output logic [RF_DATA_W-1:0] ram_data,
  output logic                 ram_we,
  output logic                 ram_re,
  input  logic [RF_DATA_W-1:0] ram_q
);

  localparam int unsigned CNT_W = RF_ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAT  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [RF_ADDR_W-1:0] src_ptr_q, dst_ptr_q;
  logic [RF_ADDR_W-1:0] src_step_q, dst_step_q;
  logic [CNT_W-1:0]     len_q, rows_done_q;
  logic [RF_DATA_W-1:0] data_q;
  logic                 aborted_q;
  logic                 last_row_c;

  // The write now in progress is the final one of the command.
  assign last_row_c = (rows_done_q + CNT_W'(1)) == len_q;

  // State register; reset drops the RAM strobes immediately via the decode below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: read, wait out the RAM latency, write, repeat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = (cmd_len == '0) ? S_FIN : S_RD;
      S_RD:    state_d = abort ? S_FIN : S_LAT;
      S_LAT:   state_d = abort ? S_FIN : S_WR;
      S_WR:    state_d = (abort || last_row_c) ? S_FIN : S_RD;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, address pointers, row counter, data holding register, abort flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      src_step_q  <= '0;
      dst_step_q  <= '0;
      len_q       <= '0;
      rows_done_q <= '0;
      data_q      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            src_ptr_q   <= cmd_src;
            dst_ptr_q   <= cmd_dst;
            src_step_q  <= cmd_src_step;
            dst_step_q  <= cmd_dst_step;
            len_q       <= cmd_len;
            rows_done_q <= '0;
            aborted_q   <= 1'b0;
          end
        end
        S_RD: begin
          if (abort) aborted_q <= 1'b1;
        end
        S_LAT: begin
          data_q <= ram_q;
          if (abort) aborted_q <= 1'b1;
        end
        S_WR: begin
          rows_done_q <= rows_done_q + CNT_W'(1);
          src_ptr_q   <= src_ptr_q + src_step_q;
          dst_ptr_q   <= dst_ptr_q + dst_step_q;
          if (abort) aborted_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decodes of registered state only; ram_q never reaches ram_data directly.
  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign done_aborted = (state_q == S_FIN) && aborted_q;
  assign rows_done    = rows_done_q;
  assign ram_re       = (state_q == S_RD);
  assign ram_we       = (state_q == S_WR);
  assign ram_addr     = (state_q == S_WR) ? dst_ptr_q : src_ptr_q;
  assign ram_data     = data_q;

endmodule

// File: tb/tb_rf_row_mover.sv
// Bench for rf_row_mover: RAM model, per-cycle schedule model, directed commands.
module tb_rf_row_mover;

  localparam int unsigned DW = 1408;
  localparam int unsigned AW = 10;
  localparam int NROWS = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_src, cmd_dst, cmd_src_step, cmd_dst_step;
  logic [AW:0]   cmd_len;
  logic          abort, busy, done, done_aborted;
  logic [AW:0]   rows_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_we, ram_re;

  rf_row_mover dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_src_step(cmd_src_step), .cmd_dst_step(cmd_dst_step),
    .cmd_len(cmd_len), .abort(abort),
    .busy(busy), .done(done), .done_aborted(done_aborted), .rows_done(rows_done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_re(ram_re),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] r;
    for (int w = 0; w < 44; w++)
      r[w*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ 32'(w * 32'h0101_0101) ^ 32'hC0DE_0000;
    return r;
  endfunction

  // Register file RAM: 1-cycle read latency, logs every access address.
  logic [DW-1:0] mem [NROWS];
  int wlog[$];
  int rlog[$];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      wlog.push_back(int'(ram_addr));
    end
    if (ram_re) begin
      ram_q <= mem[ram_addr];
      rlog.push_back(int'(ram_addr));
    end
  end

  // Golden memory and command model.
  logic [DW-1:0] model_mem [NROWS];
  bit m_active = 1'b0;
  int m_cmd_cyc, m_src, m_dst, m_ss, m_ds, m_n, m_done_rel, m_prev_rows;
  bit m_aborted;

  // Expected outputs for cycle rel after acceptance follow from the latency rules:
  // row k read in 3k+1, written in 3k+3, done one cycle after the last access.
  int rel, k, ph, e_rows, e_addr;
  bit e_ready, e_busy, e_done, e_ab, e_re, e_we;
  logic [DW-1:0] e_data;
  always @(negedge clk) begin
    if (chk_en) begin
      e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ab = 1'b0;
      e_re = 1'b0; e_we = 1'b0; e_addr = 0; e_data = '0; e_rows = 0;
      if (m_active) begin
        rel = cyc - m_cmd_cyc;
        if (rel == 0) e_rows = m_prev_rows;
        else if (rel < m_done_rel) begin
          e_ready = 1'b0; e_busy = 1'b1;
          k = (rel - 1) / 3;
          ph = (rel - 1) % 3;
          e_rows = (k < m_n) ? k : m_n;
          if (ph == 0) begin
            e_re = 1'b1; e_addr = (m_src + k * m_ss) % NROWS;
          end else if (ph == 2) begin
            e_we = 1'b1; e_addr = (m_dst + k * m_ds) % NROWS;
            e_data = model_mem[(m_src + k * m_ss) % NROWS];
          end
        end else if (rel == m_done_rel) begin
          e_ready = 1'b0; e_busy = 1'b1; e_done = 1'b1; e_ab = m_aborted; e_rows = m_n;
        end else e_rows = m_n;
      end
      chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      if (e_done) chk("done_aborted", 64'(done_aborted), 64'(e_ab));
      chk("rows_done", 64'(rows_done), 64'(e_rows));
      chk("ram_re", 64'(ram_re), 64'(e_re));
      chk("ram_we", 64'(ram_we), 64'(e_we));
      chk("re_we_exclusive", 64'(ram_re && ram_we), 64'd0);
      if (e_re || e_we) chk("ram_addr", 64'(ram_addr), 64'(e_addr));
      if (e_we) begin
        chk("ram_data_eq", 64'(ram_data == e_data), 64'd1);
        model_mem[e_addr] = e_data;
      end
    end
  end

  // Load the model for a new command accepted in the current cycle.
  task automatic model_start(input int s, input int d, input int ss, input int ds,
                             input int len, input int ab_rel);
    m_prev_rows = m_active ? m_n : 0;
    m_cmd_cyc = cyc;
    m_src = s; m_dst = d; m_ss = ss; m_ds = ds;
    if (ab_rel >= 1 && ab_rel <= 3 * len) begin
      m_n = ((ab_rel - 1) % 3 == 2) ? (ab_rel - 1) / 3 + 1 : (ab_rel - 1) / 3;
      m_done_rel = ab_rel + 1;
      m_aborted = 1'b1;
    end else begin
      m_n = len;
      m_done_rel = 3 * len + 1;
      m_aborted = 1'b0;
    end
    m_active = 1'b1;
  endtask

  // Issue one command, pulse abort in cycle ab_rel (0 = none), wait for done.
  task automatic run_cmd(input int s, input int d, input int ss, input int ds, input int len,
                         input int ab_rel, output int done_at, output bit done_ab,
                         output int rows_at_done);
    @(posedge clk); #1;
    wlog.delete(); rlog.delete();
    model_start(s, d, ss, ds, len, ab_rel);
    cmd_valid = 1'b1;
    cmd_src = AW'(s); cmd_dst = AW'(d);
    cmd_src_step = AW'(ss); cmd_dst_step = AW'(ds);
    cmd_len = (AW+1)'(len);
    done_at = -1; done_ab = 1'b0; rows_at_done = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_src = '1; cmd_dst = '1; cmd_len = '1;
    for (int t = 1; t < 4000; t++) begin
      abort = (t == ab_rel);
      if (done) begin
        done_at = t; done_ab = done_aborted; rows_at_done = int'(rows_done);
        break;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    if (done_at < 0) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  int da, ra;
  bit dab;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_src_step = '0; cmd_dst_step = '0; cmd_len = '0;
    for (int i = 0; i < NROWS; i++) begin
      mem[i] = pat(i);
      model_mem[i] = pat(i);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_aborted", 64'(done_aborted), 64'd0);
    chk("rst_rows_done", 64'(rows_done), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_data_zero", 64'(ram_data == '0), 64'd1);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_re", 64'(ram_re), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Plain copy
    run_cmd(12'h010, 12'h100, 1, 1, 4, 0, da, dab, ra);
    chk("copy_done_cycle", 64'(da), 64'd13);
    chk("copy_rows_done", 64'(ra), 64'd4);
    chk("copy_done_aborted", 64'(dab), 64'd0);
    for (int i = 0; i < 4; i++)
      chk("copy_row_data", 64'(mem[12'h100 + i] == pat(12'h010 + i)), 64'd1);

    // Zero destination stride into one MMIO row
    run_cmd(12'h020, 12'h200, 1, 0, 3, 0, da, dab, ra);
    chk("mmio_write_count", 64'(wlog.size()), 64'd3);
    foreach (wlog[i]) chk("mmio_write_addr", 64'(wlog[i]), 64'h200);
    chk("mmio_last_data", 64'(mem[12'h200] == pat(12'h022)), 64'd1);
    chk("mmio_neighbour", 64'(mem[12'h201] == pat(12'h201)), 64'd1);

    // Address wrap on the source side
    run_cmd(12'h3FE, 12'h0F0, 1, 1, 4, 0, da, dab, ra);
    chk("wrap_read_count", 64'(rlog.size()), 64'd4);
    if (rlog.size() == 4) begin
      chk("wrap_rd0", 64'(rlog[0]), 64'h3FE);
      chk("wrap_rd1", 64'(rlog[1]), 64'h3FF);
      chk("wrap_rd2", 64'(rlog[2]), 64'h000);
      chk("wrap_rd3", 64'(rlog[3]), 64'h001);
    end
    chk("wrap_write_count", 64'(wlog.size()), 64'd4);
    foreach (wlog[i]) chk("wrap_write_addr", 64'(wlog[i]), 64'(12'h0F0 + i));

    // len = 0
    run_cmd(12'h030, 12'h130, 1, 1, 0, 0, da, dab, ra);
    chk("len0_done_cycle", 64'(da), 64'd1);
    chk("len0_done_aborted", 64'(dab), 64'd0);
    chk("len0_no_access", 64'(rlog.size() + wlog.size()), 64'd0);
    chk("len0_ready_cycle2", 64'(cmd_ready), 64'd1);

    // Abort in LAT of row 2
    run_cmd(12'h040, 12'h300, 1, 1, 8, 8, da, dab, ra);
    chk("abort_rows_done", 64'(ra), 64'd2);
    chk("abort_done_aborted", 64'(dab), 64'd1);
    chk("abort_done_cycle", 64'(da), 64'd9);
    chk("abort_row2_untouched", 64'(mem[12'h302] == pat(12'h302)), 64'd1);
    chk("abort_row1_copied", 64'(mem[12'h301] == pat(12'h041)), 64'd1);

    // Abort on the final row's write still counts that row
    run_cmd(12'h060, 12'h360, 1, 1, 2, 6, da, dab, ra);
    chk("abort_last_rows", 64'(ra), 64'd2);
    chk("abort_last_flag", 64'(dab), 64'd1);

    // Full-range command
    run_cmd(0, 0, 1, 1, 1024, 0, da, dab, ra);
    chk("full_rows_done", 64'(ra), 64'd1024);
    chk("full_done_cycle", 64'(da), 64'd3073);

    // Reset in the middle of a write
    @(posedge clk); #1;
    wlog.delete(); rlog.delete();
    model_start(12'h050, 12'h350, 1, 1, 4, 0);
    cmd_valid = 1'b1;
    cmd_src = AW'(12'h050); cmd_dst = AW'(12'h350);
    cmd_src_step = AW'(1); cmd_dst_step = AW'(1); cmd_len = (AW+1)'(4);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_we_before", 64'(ram_we), 64'd1);
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_we_async", 64'(ram_we), 64'd0);
    chk("rstmid_re_async", 64'(ram_re), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_active = 1'b0;
    chk("rstmid_ready", 64'(cmd_ready), 64'd1);
    chk("rstmid_no_write", 64'(wlog.size()), 64'd0);
    chk_en = 1'b1;
    run_cmd(12'h070, 12'h370, 1, 1, 1, 0, da, dab, ra);
    chk("post_rst_done_cycle", 64'(da), 64'd4);
    chk("post_rst_rows", 64'(ra), 64'd1);
    chk("post_rst_data", 64'(mem[12'h370] == pat(12'h070)), 64'd1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
